// File: rtl/uart_frame_packer.sv
// Reassembles the UART_RX byte stream into FFT frames (low byte first, word 0 first) and
// presents each complete frame on a flat bus with valid/ack, timeout resync and overrun flag.
module uart_frame_packer #(
    parameter int FFT_SIZE       = 16,
    parameter int DATA_LENGTH    = 8,
    parameter int WORD_SIZE      = 2 * DATA_LENGTH,
    parameter int TIMEOUT_CLOCKS = 26040
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [DATA_LENGTH-1:0]        i_byte,
    input  logic                          i_byte_valid,
    input  logic                          i_frame_ack,
    output logic [FFT_SIZE*WORD_SIZE-1:0] o_frame,
    output logic                          o_frame_valid,
    output logic [$clog2(2*FFT_SIZE):0]   o_byte_index,
    output logic                          o_overrun,
    output logic                          o_timeout
);

    localparam int NumBytes = 2 * FFT_SIZE;
    localparam int IdxW     = $clog2(NumBytes) + 1;
    localparam int CntW     = $clog2(TIMEOUT_CLOCKS + 1);
    localparam int FrameW   = FFT_SIZE * WORD_SIZE;

    typedef enum logic {StIdle, StCollect} state_e;

    state_e              state_q, state_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [FrameW-1:0]   buf_q, buf_d;
    logic [FrameW-1:0]   frame_q, frame_d;
    logic                valid_q, valid_d;
    logic                overrun_q, overrun_d;
    logic                timeout_q, timeout_d;
    logic                complete;
    logic                ack_eff;

    // Byte b lives at buf[b*DATA_LENGTH], so the buffer already has the o_frame word layout.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        buf_d     = buf_q;
        frame_d   = frame_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        timeout_d = 1'b0;
        complete  = 1'b0;
        ack_eff   = i_frame_ack && valid_q;

        if (ack_eff) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                idx_d = '0;
                cnt_d = '0;
                if (i_byte_valid) begin
                    buf_d[DATA_LENGTH-1:0] = i_byte;
                    idx_d   = IdxW'(1);
                    state_d = StCollect;
                end
            end
            StCollect: begin
                if (i_byte_valid) begin
                    buf_d[int'(idx_q) * DATA_LENGTH +: DATA_LENGTH] = i_byte;
                    cnt_d = '0;
                    if (idx_q == IdxW'(NumBytes - 1)) begin
                        complete = 1'b1;
                        idx_d    = '0;
                        state_d  = StIdle;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end else if (cnt_q == CntW'(TIMEOUT_CLOCKS - 1)) begin
                    timeout_d = 1'b1;
                    idx_d     = '0;
                    cnt_d     = '0;
                    state_d   = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // A same-cycle ack frees the output slot, so the new frame replaces the old one.
        if (complete) begin
            if (!valid_q || ack_eff) begin
                frame_d = buf_d;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            cnt_q     <= '0;
            buf_q     <= '0;
            frame_q   <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            buf_q     <= buf_d;
            frame_q   <= frame_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_frame       = frame_q;
    assign o_frame_valid = valid_q;
    assign o_byte_index  = idx_q;
    assign o_overrun     = overrun_q;
    assign o_timeout     = timeout_q;

endmodule

// File: tb/tb_uart_frame_packer.sv
// Directed bench for uart_frame_packer: a queue-based reference model checked every cycle,
// plus literal expectations on the assembled words and pulse counts.
module tb_uart_frame_packer;

    localparam int FFT  = 16;
    localparam int DL   = 8;
    localparam int WS   = 16;
    localparam int TO   = 20;
    localparam int FW   = FFT * WS;
    localparam int NB   = 2 * FFT;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic [DL-1:0] i_byte = '0;
    logic          i_byte_valid = 1'b0;
    logic          i_frame_ack = 1'b0;
    logic [FW-1:0] o_frame;
    logic          o_frame_valid;
    logic [5:0]    o_byte_index;
    logic          o_overrun;
    logic          o_timeout;

    uart_frame_packer #(
        .FFT_SIZE      (FFT),
        .DATA_LENGTH   (DL),
        .WORD_SIZE     (WS),
        .TIMEOUT_CLOCKS(TO)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_byte       (i_byte),
        .i_byte_valid (i_byte_valid),
        .i_frame_ack  (i_frame_ack),
        .o_frame      (o_frame),
        .o_frame_valid(o_frame_valid),
        .o_byte_index (o_byte_index),
        .o_overrun    (o_overrun),
        .o_timeout    (o_timeout)
    );

    always #5 i_clk = ~i_clk;

    int tests_run    = 0;
    int tests_failed = 0;
    int ov_cnt       = 0;
    int to_cnt       = 0;
    bit checking     = 1'b0;

    // Reference model state
    logic [7:0]    m_bytes[$];
    int            m_idle  = 0;
    logic [FW-1:0] m_frame = '0;
    bit            m_valid = 1'b0;
    bit            m_ov    = 1'b0;
    bit            m_to    = 1'b0;

    task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] word(input int k);
        return o_frame[k*WS +: WS];
    endfunction

    // Model: bytes accumulate in a queue; a full queue becomes a frame; a long silence
    // while the queue is non-empty throws the partial frame away.
    initial begin
        forever begin
            @(posedge i_clk or negedge i_rst);
            if (!i_rst) begin
                m_bytes.delete();
                m_idle  = 0;
                m_frame = '0;
                m_valid = 1'b0;
                m_ov    = 1'b0;
                m_to    = 1'b0;
            end else begin
                bit            ack;
                bit            done;
                bit            was_valid;
                logic [FW-1:0] nf;
                ack  = i_frame_ack && m_valid;
                done = 1'b0;
                nf   = '0;
                m_ov = 1'b0;
                m_to = 1'b0;
                if (i_byte_valid) begin
                    m_bytes.push_back(i_byte);
                    m_idle = 0;
                    if (m_bytes.size() == NB) begin
                        for (int b = 0; b < NB; b++) nf[b*8 +: 8] = m_bytes[b];
                        m_bytes.delete();
                        done = 1'b1;
                    end
                end else if (m_bytes.size() > 0) begin
                    if (m_idle == TO - 1) begin
                        m_bytes.delete();
                        m_idle = 0;
                        m_to   = 1'b1;
                    end else begin
                        m_idle++;
                    end
                end
                was_valid = m_valid;
                if (ack) m_valid = 1'b0;
                if (done) begin
                    if (!was_valid || ack) begin
                        m_frame = nf;
                        m_valid = 1'b1;
                    end else begin
                        m_ov = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge i_clk);
            if (checking) begin
                check("valid", FW'(o_frame_valid), FW'(m_valid));
                check("index", FW'(o_byte_index), FW'(m_bytes.size()));
                check("overrun", FW'(o_overrun), FW'(m_ov));
                check("timeout", FW'(o_timeout), FW'(m_to));
                check("frame", o_frame, m_frame);
                if (o_overrun) ov_cnt++;
                if (o_timeout) to_cnt++;
            end
        end
    end

    task automatic send_bytes(input int n, input logic [7:0] start, input logic [7:0] step,
                              input bit ack_last);
        for (int i = 0; i < n; i++) begin
            @(negedge i_clk);
            i_byte       = start + 8'(i) * step;
            i_byte_valid = 1'b1;
            i_frame_ack  = ack_last && (i == n - 1);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge i_clk);
            i_byte_valid = 1'b0;
            i_frame_ack  = 1'b0;
        end
    endtask

    task automatic ack_frame();
        @(negedge i_clk);
        i_byte_valid = 1'b0;
        i_frame_ack  = 1'b1;
        @(negedge i_clk);
        i_frame_ack  = 1'b0;
    endtask

    initial begin
        #1 i_rst = 1'b0;
        repeat (3) @(negedge i_clk);
        #2 i_rst = 1'b1;
        checking = 1'b1;
        idle(1);
        check("rst_valid", FW'(o_frame_valid), FW'(0));
        check("rst_index", FW'(o_byte_index), FW'(0));
        check("rst_frame", o_frame, '0);

        // Frame 0x00..0x1F
        send_bytes(31, 8'h00, 8'h01, 1'b0);
        idle(1);
        check("idx31", FW'(o_byte_index), FW'(31));
        check("not_yet_valid", FW'(o_frame_valid), FW'(0));
        send_bytes(1, 8'h1F, 8'h01, 1'b0);
        idle(1);
        check("f1_valid", FW'(o_frame_valid), FW'(1));
        check("f1_w0", FW'(word(0)), FW'(16'h0100));
        check("f1_w1", FW'(word(1)), FW'(16'h0302));
        check("f1_w15", FW'(word(15)), FW'(16'h1F1E));
        check("f1_idx", FW'(o_byte_index), FW'(0));

        // Overrun: second frame while first is pending
        send_bytes(NB, 8'h40, 8'h01, 1'b0);
        idle(2);
        check("ov_count", FW'(ov_cnt), FW'(1));
        check("ov_keep_w0", FW'(word(0)), FW'(16'h0100));
        check("ov_valid", FW'(o_frame_valid), FW'(1));
        ack_frame();
        idle(1);
        check("ack_clears", FW'(o_frame_valid), FW'(0));
        ack_frame();

        // Timeout after a 5-byte partial frame, then an all-0xAA frame
        send_bytes(5, 8'h11, 8'h01, 1'b0);
        idle(22);
        check("to_count", FW'(to_cnt), FW'(1));
        check("to_idx", FW'(o_byte_index), FW'(0));
        send_bytes(NB, 8'hAA, 8'h00, 1'b0);
        idle(1);
        check("aa_w0", FW'(word(0)), FW'(16'hAAAA));
        check("aa_w9", FW'(word(9)), FW'(16'hAAAA));

        // Ack coincident with the last byte of the next frame
        send_bytes(NB, 8'h80, 8'h01, 1'b1);
        idle(2);
        check("ackload_ov", FW'(ov_cnt), FW'(1));
        check("ackload_w0", FW'(word(0)), FW'(16'h8180));
        check("ackload_valid", FW'(o_frame_valid), FW'(1));

        // Reset after 10 bytes, then a fresh frame
        send_bytes(10, 8'h60, 8'h01, 1'b0);
        @(negedge i_clk);
        i_byte_valid = 1'b0;
        #2 i_rst = 1'b0;
        @(negedge i_clk);
        check("mid_rst_idx", FW'(o_byte_index), FW'(0));
        check("mid_rst_valid", FW'(o_frame_valid), FW'(0));
        #2 i_rst = 1'b1;
        send_bytes(NB, 8'h20, 8'h01, 1'b0);
        idle(1);
        check("post_rst_w0", FW'(word(0)), FW'(16'h2120));
        check("post_rst_w15", FW'(word(15)), FW'(16'h3F3E));
        ack_frame();

        // Byte lands on the timeout terminal count and must win
        send_bytes(10, 8'h50, 8'h01, 1'b0);
        idle(TO - 1);
        send_bytes(22, 8'h5A, 8'h01, 1'b0);
        idle(2);
        check("coinc_to", FW'(to_cnt), FW'(1));
        check("coinc_valid", FW'(o_frame_valid), FW'(1));
        check("coinc_w4", FW'(word(4)), FW'(16'h5958));
        check("coinc_w5", FW'(word(5)), FW'(16'h5B5A));
        check("coinc_w15", FW'(word(15)), FW'(16'h6F6E));

        idle(3);
        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/uart_frame_packer.md
Name: uart_frame_packer

Overview:
- Inbound counterpart of the FFT result serializer that feeds UART_TX.
- Sits directly after UART_RX and accepts the received byte stream.
- Reassembles FFT_SIZE words from 2*FFT_SIZE bytes: low byte first, then high byte, word 0 first. This is the same order the FFT top uses to transmit results.
- Delivers completed frames as a flat word bus with a valid/ack handshake, with inter-byte timeout resync and overrun detection.

Parameters:
- FFT_SIZE, 16, words per frame.
- WORD_SIZE, 16, bits per word; fixed at 2*DATA_LENGTH.
- DATA_LENGTH, 8, bits per UART byte.
- TIMEOUT_CLOCKS, 26040, idle clocks after which a partial frame is discarded. Default is 3 byte times at CLOCK_PER_BIT 868.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  asynchronous reset, active-low.
- i_byte  in  DATA_LENGTH  received byte; sampled only when i_byte_valid=1.
- i_byte_valid  in  1  single-cycle strobe, one per received byte.
- i_frame_ack  in  1  consumer accepts the current frame.
- o_frame  out  FFT_SIZE*WORD_SIZE  word k occupies bits [k*WORD_SIZE +: WORD_SIZE].
- o_frame_valid  out  1  o_frame holds an unconsumed complete frame.
- o_byte_index  out  log2(2*FFT_SIZE)+1  bytes collected in the current partial frame.
- o_overrun  out  1  one-cycle pulse: a completed frame was dropped.
- o_timeout  out  1  one-cycle pulse: a partial frame was discarded.

Behaviour:
- Reset (i_rst=0, asynchronous) clears all outputs, the working buffer, the byte index, the timeout counter, and the state.
- Reset mid-frame discards all collected bytes.
- State machine, two states:
  - IDLE: byte index = 0, timeout counter held at 0. On i_byte_valid, store the byte and go to COLLECT with index = 1.
  - COLLECT: on each i_byte_valid, store the byte and increment the index.
    - Byte 2k is stored to working word k bits [7:0].
    - Byte 2k+1 is stored to working word k bits [15:8].
    - On the byte that makes index = 2*FFT_SIZE, the frame is complete: go to IDLE with index = 0 in the next cycle.
- Timeout:
  - In COLLECT the counter increments every clock without i_byte_valid and clears on i_byte_valid.
  - When the counter reaches TIMEOUT_CLOCKS-1 with no byte arriving, pulse o_timeout, return to IDLE with index 0, and keep the working buffer contents (it is don't-care).
  - If a byte arrives in the same cycle as the terminal count, the byte wins: no timeout, and the byte is stored.
- Frame completion (same cycle the last byte is stored):
  - o_frame_valid=0: copy the working buffer (including the last byte) to o_frame; o_frame_valid=1 from the next cycle.
  - o_frame_valid=1 and no i_frame_ack in this cycle: drop the new frame, keep o_frame unchanged, pulse o_overrun next cycle.
  - o_frame_valid=1 with i_frame_ack in the same cycle: ack and load happen together. o_frame is loaded with the new frame and o_frame_valid stays 1. No overrun.
- Handshake:
  - o_frame_valid clears the cycle after i_frame_ack while valid.
  - i_frame_ack while not valid is ignored.
  - o_frame is stable while o_frame_valid=1.
- Latency: last byte strobe to o_frame_valid is 1 clock.
- Reception continues while a frame is pending. Back-to-back strobes on consecutive cycles are accepted, with no bubbles.
- The byte index never exceeds 2*FFT_SIZE-1 while in COLLECT; the wrap to 0 is only through completion or timeout.

Test Plan:
- Reset, then 32 strobes with bytes 0x00..0x1F. → o_frame_valid=1 one clock after the 32nd strobe; word0=0x0100, word1=0x0302, word15=0x1F1E; o_byte_index=0.
- Pending frame never acked, second full 32-byte frame sent. → o_overrun pulses once; o_frame still holds the first frame; o_frame_valid stays 1.
- TIMEOUT_CLOCKS=20: send 5 bytes, wait 20 idle clocks. → o_timeout pulses once; index=0; a following 32-byte frame of 0xAA assembles as all words 0xAAAA.
- i_frame_ack asserted in the same cycle as the 32nd byte of the next frame. → no overrun; o_frame updates to the new frame; o_frame_valid remains 1.
- i_rst low after 10 bytes, then released, then 32 bytes sent. → no valid pulse until the 32nd post-reset byte; frame matches the post-reset data only.
- Byte strobe coincident with the timeout terminal count. → no o_timeout; the byte is stored; the frame still completes correctly.
